// File: rtl/sonar_pulse_meter.sv
// Sonar echo pulse-width meter: sync, glitch filter, width/timeout FSM.
// Ports: clk, reset_n, sonarin, Avalon-MM (address/read/readdata/write/writedata), irq.
module sonar_pulse_meter #(
  parameter int FILTER_LEN     = 4,
  parameter int WIDTH_BITS     = 24,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sonarin,
  input  logic [1:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        irq
);

  localparam logic [1:0] ARM       = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] HIGH      = 2'd2;

  localparam logic [3:0]  FL_LAST = 4'(FILTER_LEN - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH_BITS-1:0] CNT_MAX = '1;

  logic                  sync1_q, sync2_q;
  logic [3:0]            flt_q, flt_d;
  logic                  lvl_q, lvl_d;
  logic [1:0]            state_q, state_d;
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]           tmr_q, tmr_d;
  logic                  ovf_q, ovf_d;
  logic [WIDTH_BITS-1:0] width_q, width_d;
  logic                  valid_q, valid_d;
  logic                  ovfl_q, ovfl_d;
  logic                  tmo_q, tmo_d;
  logic                  en_q, en_d;
  logic                  irq_en_q, irq_en_d;
  logic [15:0]           count_q, count_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q;
  logic                  latch, tmo_fire;
  logic                  rd_width, wr_sts, wr_ctl, wr_cnt;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata[31:3];

  assign rd_width = read  && (address == 2'd0);
  assign wr_sts   = write && (address == 2'd1);
  assign wr_ctl   = write && (address == 2'd2);
  assign wr_cnt   = write && (address == 2'd3);

  // A run of FILTER_LEN samples differing from lvl flips it.
  always_comb begin
    flt_d = '0;
    lvl_d = lvl_q;
    if (sync2_q != lvl_q) begin
      if (flt_q == FL_LAST) lvl_d = ~lvl_q;
      else                  flt_d = flt_q + 4'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    ovf_d    = ovf_q;
    latch    = 1'b0;
    tmo_fire = 1'b0;
    if (!en_q) begin
      state_d = ARM;
      cnt_d   = '0;
      tmr_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ARM: if (!lvl_q) state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (lvl_q) begin
            // Rise cycle is the first high cycle, so it counts as 1.
            cnt_d   = WIDTH_BITS'(1);
            state_d = HIGH;
          end else if (tmr_q == TO_LAST) begin
            tmo_fire = 1'b1;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
        HIGH: begin
          if (lvl_q) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + WIDTH_BITS'(1);
          end else begin
            latch   = 1'b1;
            ovf_d   = 1'b0;
            tmr_d   = '0;
            state_d = WAIT_RISE;
          end
        end
        default: state_d = ARM;
      endcase
    end
  end

  // Set beats clear on every collision.
  always_comb begin
    width_d  = latch ? cnt_q : width_q;
    ovfl_d   = latch ? ovf_q : ovfl_q;
    valid_d  = valid_q;
    if (rd_width || (wr_sts && writedata[0])) valid_d = 1'b0;
    if (latch) valid_d = 1'b1;
    tmo_d    = tmo_q;
    if (wr_sts && writedata[2]) tmo_d = 1'b0;
    if (tmo_fire) tmo_d = 1'b1;
    en_d     = wr_ctl ? writedata[0] : en_q;
    irq_en_d = wr_ctl ? writedata[1] : irq_en_q;
    count_d  = count_q;
    if (wr_cnt) count_d = '0;
    if (latch)  count_d = (wr_cnt ? 16'd0 : count_q) + 16'd1;
  end

  always_comb begin
    rdata_d = '0;
    if (read) begin
      case (address)
        2'd0: rdata_d = 32'(width_q);
        2'd1: rdata_d = {28'd0, lvl_q, tmo_q, ovfl_q, valid_q};
        2'd2: rdata_d = {30'd0, irq_en_q, en_q};
        2'd3: rdata_d = {16'd0, count_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      flt_q    <= '0;
      lvl_q    <= 1'b0;
      state_q  <= ARM;
      cnt_q    <= '0;
      tmr_q    <= '0;
      ovf_q    <= 1'b0;
      width_q  <= '0;
      valid_q  <= 1'b0;
      ovfl_q   <= 1'b0;
      tmo_q    <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      count_q  <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= sonarin;
      sync2_q  <= sync1_q;
      flt_q    <= flt_d;
      lvl_q    <= lvl_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      ovf_q    <= ovf_d;
      width_q  <= width_d;
      valid_q  <= valid_d;
      ovfl_q   <= ovfl_d;
      tmo_q    <= tmo_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_en_q & valid_q;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sonar_pulse_meter.sv
// Directed bench for sonar_pulse_meter.
// FILTER_LEN=4, WIDTH_BITS=8, TIMEOUT_CYCLES=1000.
module tb_sonar_pulse_meter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sonarin;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  sonar_pulse_meter #(
    .FILTER_LEN(4),
    .WIDTH_BITS(8),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sonarin(sonarin),
    .address(address),
    .read(read),
    .readdata(readdata),
    .write(write),
    .writedata(writedata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // All bus/pin tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic pulse(input int n);
    sonarin = 1'b1;
    repeat (n) @(negedge clk);
    sonarin = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sonarin = 1'b0; address = '0;
    read = 1'b0; write = 1'b0; writedata = '0;
    idle(3);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    idle(2);
    bus_rd(2'd0, rd); chk("rst_width", rd, 32'h0);
    bus_rd(2'd1, rd); chk("rst_status", rd, 32'h0);
    bus_rd(2'd2, rd); chk("rst_ctrl", rd, 32'h0);
    bus_rd(2'd3, rd); chk("rst_count", rd, 32'h0);

    // Basic pulse with interrupt
    bus_wr(2'd2, 32'h3);
    bus_rd(2'd2, rd); chk("ctrl_rw", rd, 32'h3);
    idle(10);
    pulse(200);
    idle(12);
    chk("basic_irq", {31'd0, irq}, 32'h1);
    bus_rd(2'd1, rd); chk("basic_status", rd, 32'h1);
    bus_rd(2'd3, rd); chk("basic_count", rd, 32'h1);
    bus_rd(2'd0, rd); chk("basic_width", rd, 32'd200);
    chk("irq_hold", {31'd0, irq}, 32'h1);
    idle(1);
    chk("irq_drop", {31'd0, irq}, 32'h0);
    bus_rd(2'd1, rd); chk("status_clr", rd, 32'h0);

    // Glitch filter
    bus_wr(2'd3, 32'h0);
    repeat (5) begin
      pulse(3);
      idle(47);
    end
    pulse(100);
    idle(12);
    bus_rd(2'd3, rd); chk("glitch_count", rd, 32'h1);
    bus_rd(2'd1, rd); chk("glitch_status", rd, 32'h1);
    bus_rd(2'd0, rd); chk("glitch_width", rd, 32'd100);

    // Overflow then a normal pulse
    pulse(400);
    idle(12);
    bus_rd(2'd1, rd); chk("ovf_status", rd, 32'h3);
    bus_rd(2'd0, rd); chk("ovf_width", rd, 32'd255);
    pulse(100);
    idle(12);
    bus_rd(2'd1, rd); chk("post_ovf_status", rd, 32'h1);
    bus_rd(2'd0, rd); chk("post_ovf_width", rd, 32'd100);
    bus_rd(2'd3, rd); chk("ovf_count", rd, 32'h3);

    // Timeout
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd1, 32'h5);
    bus_wr(2'd2, 32'h3);
    idle(900);
    bus_rd(2'd1, rd); chk("tmo_early", rd, 32'h0);
    idle(200);
    bus_rd(2'd1, rd); chk("tmo_set", rd, 32'h4);
    chk("tmo_no_irq", {31'd0, irq}, 32'h0);
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd1, 32'h4);
    bus_rd(2'd1, rd); chk("tmo_clr", rd, 32'h0);

    // Partial pulse at enable
    sonarin = 1'b1;
    idle(20);
    bus_rd(2'd1, rd); chk("lvl_high", rd, 32'h8);
    bus_wr(2'd3, 32'h0);
    bus_wr(2'd2, 32'h3);
    idle(300);
    sonarin = 1'b0;
    idle(12);
    bus_rd(2'd3, rd); chk("partial_count", rd, 32'h0);
    bus_rd(2'd1, rd); chk("partial_status", rd, 32'h0);
    pulse(200);
    idle(12);
    bus_rd(2'd3, rd); chk("after_part_count", rd, 32'h1);
    bus_rd(2'd0, rd); chk("after_part_width", rd, 32'd200);

    // Latch colliding with a WIDTH read
    pulse(150);
    idle(12);
    pulse(120);
    idle(6);
    bus_rd(2'd0, rd); chk("coll_old_width", rd, 32'd150);
    bus_rd(2'd1, rd); chk("coll_valid", rd, 32'h1);
    bus_rd(2'd0, rd); chk("coll_new_width", rd, 32'd120);
    bus_rd(2'd3, rd); chk("coll_count", rd, 32'h3);

    // Reset mid-pulse
    pulse(50);
    idle(12);
    chk("pre_rst_irq", {31'd0, irq}, 32'h1);
    sonarin = 1'b1;
    idle(20);
    reset_n = 1'b0;
    sonarin = 1'b0;
    #1;
    chk("rst_mid_irq", {31'd0, irq}, 32'h0);
    chk("rst_mid_rdata", readdata, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    bus_rd(2'd0, rd); chk("rst2_width", rd, 32'h0);
    bus_rd(2'd1, rd); chk("rst2_status", rd, 32'h0);
    bus_rd(2'd2, rd); chk("rst2_ctrl", rd, 32'h0);
    bus_rd(2'd3, rd); chk("rst2_count", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
